// File: rtl/axis_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_packet_fifo
// Brief    : Store-and-forward AXI4-Stream packet FIFO; oversize packets are dropped whole.
// Revision : 1.0 - initial release
// ============================================================================
module axis_packet_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 512
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic [WIDTH-1:0]         s_axis_tdata,
   input  logic [WIDTH/8-1:0]       s_axis_tkeep,
   input  logic                     s_axis_tlast,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic [WIDTH-1:0]         m_axis_tdata,
   output logic [WIDTH/8-1:0]       m_axis_tkeep,
   output logic                     m_axis_tlast,
   output logic [31:0]              drop_count,
   output logic [$clog2(DEPTH):0]   pkt_count
);
   localparam int c_AW = $clog2(DEPTH);
   localparam int c_KW = WIDTH / 8;
   localparam int c_EW = WIDTH + c_KW + 1;
   localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(DEPTH);

   typedef enum logic [0:0] {
      ST_ACCEPT = 1'b0,
      ST_DROP   = 1'b1
   } wr_state_t;

   logic [c_EW-1:0] r_mem [DEPTH];
   wr_state_t       r_state;
   wr_state_t       w_state_nxt;
   logic [c_AW:0]   r_wr_ptr;
   logic [c_AW:0]   r_wr_commit;
   logic [c_AW:0]   r_rd_ptr;
   logic [c_AW:0]   r_fetch_ptr;
   logic            r_s_ready;
   logic [31:0]     r_drop_count;
   logic [c_AW:0]   r_pkt_count;

   logic            w_beat;
   logic            w_full;
   logic            w_wr_en;
   logic            w_commit;
   logic            w_rewind;
   logic            w_drop;

   assign w_beat = s_axis_tvalid & r_s_ready;
   assign w_full = (r_wr_ptr - r_rd_ptr) == c_DEPTH;

   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      w_commit    = 1'b0;
      w_rewind    = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         ST_ACCEPT: begin
            if (w_beat) begin
               if (!w_full) begin
                  w_wr_en  = 1'b1;
                  w_commit = s_axis_tlast;
               end else begin
                  // Roll back to the last packet boundary so the partial frame vanishes
                  w_rewind = 1'b1;
                  if (s_axis_tlast) w_drop = 1'b1;
                  else              w_state_nxt = ST_DROP;
               end
            end
         end
         ST_DROP: begin
            if (w_beat && s_axis_tlast) begin
               w_drop      = 1'b1;
               w_state_nxt = ST_ACCEPT;
            end
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state      <= ST_ACCEPT;
         r_s_ready    <= 1'b0;
         r_wr_ptr     <= '0;
         r_wr_commit  <= '0;
         r_drop_count <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_s_ready <= 1'b1;
         if (w_wr_en)       r_wr_ptr <= r_wr_ptr + 1'b1;
         else if (w_rewind) r_wr_ptr <= r_wr_commit;
         if (w_commit)      r_wr_commit <= r_wr_ptr + 1'b1;
         if (w_drop)        r_drop_count <= r_drop_count + 32'd1;
      end
   end

   always_ff @(posedge aclk) begin
      if (w_wr_en) r_mem[r_wr_ptr[c_AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
   end

   // Read path: fetch pointer runs ahead of rd_ptr into a registered RAM read
   // and a 2-entry skid; rd_ptr only moves on the output handshake.
   logic [c_EW-1:0] r_rdata;
   logic            r_inflight;
   logic [1:0]      r_cnt;
   logic [c_EW-1:0] r_e0;
   logic [c_EW-1:0] r_e1;
   logic            w_avail;
   logic            w_fetch;
   logic            w_pop;
   logic            w_push;
   logic            w_pop_last;

   assign w_avail    = r_fetch_ptr != r_wr_commit;
   assign w_pop      = (r_cnt != 2'd0) & m_axis_tready;
   assign w_push     = r_inflight;
   assign w_pop_last = w_pop & r_e0[c_EW-1];
   assign w_fetch    = w_avail &
                       (({1'b0, r_cnt} + {2'b0, r_inflight}) <= (3'd1 + {2'b0, w_pop}));

   always_ff @(posedge aclk) begin
      if (w_fetch) r_rdata <= r_mem[r_fetch_ptr[c_AW-1:0]];
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_fetch_ptr <= '0;
         r_rd_ptr    <= '0;
         r_inflight  <= 1'b0;
         r_cnt       <= 2'd0;
         r_e0        <= '0;
         r_e1        <= '0;
         r_pkt_count <= '0;
      end else begin
         r_inflight <= w_fetch;
         if (w_fetch) r_fetch_ptr <= r_fetch_ptr + 1'b1;
         if (w_pop)   r_rd_ptr    <= r_rd_ptr + 1'b1;
         case (r_cnt)
            2'd0: begin
               if (w_push) begin
                  r_e0  <= r_rdata;
                  r_cnt <= 2'd1;
               end
            end
            2'd1: begin
               if (w_push && w_pop) begin
                  r_e0 <= r_rdata;
               end else if (w_push) begin
                  r_e1  <= r_rdata;
                  r_cnt <= 2'd2;
               end else if (w_pop) begin
                  r_cnt <= 2'd0;
               end
            end
            default: begin
               if (w_pop) begin
                  r_e0 <= r_e1;
                  if (w_push) r_e1  <= r_rdata;
                  else        r_cnt <= 2'd1;
               end
            end
         endcase
         case ({w_commit, w_pop_last})
            2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
            2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
            default: r_pkt_count <= r_pkt_count;
         endcase
      end
   end

   assign s_axis_tready = r_s_ready;
   assign m_axis_tvalid = r_cnt != 2'd0;
   assign m_axis_tdata  = r_e0[WIDTH-1:0];
   assign m_axis_tkeep  = r_e0[WIDTH +: c_KW];
   assign m_axis_tlast  = r_e0[c_EW-1];
   assign drop_count    = r_drop_count;
   assign pkt_count     = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axis_packet_fifo
// Brief    : Directed self-checking bench for axis_packet_fifo (DEPTH 16 and 128 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_packet_fifo;
   localparam int W  = 64;
   localparam int KW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic aresetn = 1'b0;

   logic          a_sv = 1'b0, a_sl = 1'b0, a_mr = 1'b0;
   logic [W-1:0]  a_sd = '0;
   logic [KW-1:0] a_sk = '0;
   logic          a_sr, a_mv, a_ml;
   logic [W-1:0]  a_md;
   logic [KW-1:0] a_mk;
   logic [31:0]   a_dc;
   logic [4:0]    a_pc;

   logic          b_sv = 1'b0, b_sl = 1'b0, b_mr = 1'b0, b_rand = 1'b0;
   logic [W-1:0]  b_sd = '0;
   logic [KW-1:0] b_sk = '0;
   logic          b_sr, b_mv, b_ml;
   logic [W-1:0]  b_md;
   logic [KW-1:0] b_mk;
   logic [31:0]   b_dc;
   logic [7:0]    b_pc;

   axis_packet_fifo #(.WIDTH(W), .DEPTH(16)) u_a (
      .aclk(clk), .aresetn(aresetn),
      .s_axis_tvalid(a_sv), .s_axis_tready(a_sr), .s_axis_tdata(a_sd),
      .s_axis_tkeep(a_sk), .s_axis_tlast(a_sl),
      .m_axis_tvalid(a_mv), .m_axis_tready(a_mr), .m_axis_tdata(a_md),
      .m_axis_tkeep(a_mk), .m_axis_tlast(a_ml),
      .drop_count(a_dc), .pkt_count(a_pc)
   );

   axis_packet_fifo #(.WIDTH(W), .DEPTH(128)) u_b (
      .aclk(clk), .aresetn(aresetn),
      .s_axis_tvalid(b_sv), .s_axis_tready(b_sr), .s_axis_tdata(b_sd),
      .s_axis_tkeep(b_sk), .s_axis_tlast(b_sl),
      .m_axis_tvalid(b_mv), .m_axis_tready(b_mr), .m_axis_tdata(b_md),
      .m_axis_tkeep(b_mk), .m_axis_tlast(b_ml),
      .drop_count(b_dc), .pkt_count(b_pc)
   );

   typedef struct {
      logic [72:0] v;
      int          cyc;
   } beat_t;

   beat_t       a_got[$];
   beat_t       b_got[$];
   logic [72:0] b_exp[$];
   int cyc = 0;
   int n_assert = 0;
   int n_fail = 0;

   // Inputs change 1ns after posedge, so at negedge they match what the next edge sees
   always @(negedge clk) begin
      cyc++;
      if (aresetn && a_mv && a_mr) a_got.push_back('{{a_ml, a_mk, a_md}, cyc});
      if (aresetn && b_mv && b_mr) b_got.push_back('{{b_ml, b_mk, b_md}, cyc});
   end

   always @(posedge clk) begin
      #1;
      b_mr = b_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check_eq(input string tag, input logic [72:0] got, input logic [72:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      tick(1);
      aresetn = 1'b0;
      a_sv = 1'b0; a_sl = 1'b0;
      b_sv = 1'b0; b_sl = 1'b0;
      tick(1);
      aresetn = 1'b1;
      tick(1);
      a_got.delete();
      b_got.delete();
   endtask

   task automatic a_beat(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l);
      tick(1);
      a_sv = 1'b1; a_sd = d; a_sk = k; a_sl = l;
   endtask

   task automatic a_idle();
      tick(1);
      a_sv = 1'b0; a_sl = 1'b0;
   endtask

   task automatic a_expect(input string tag, input int idx, input logic [W-1:0] d,
                           input logic [KW-1:0] k, input logic l);
      if (idx < a_got.size()) check_eq(tag, a_got[idx].v, {l, k, d});
   endtask

   task automatic b_pkt(input int p);
      for (int i = 0; i < 64; i++) begin
         tick(1);
         b_sv = 1'b1;
         b_sd = {32'(p), 32'(i)};
         b_sk = (i == 63) ? 8'(8'hFF >> (p % 8)) : 8'hFF;
         b_sl = (i == 63);
         b_exp.push_back({b_sl, b_sk, b_sd});
      end
   endtask

   task automatic b_wait_drain(input string tag);
      for (int k = 0; k < 3000; k++) begin
         if (b_pc == 8'd0 && !b_mv) break;
         tick(1);
      end
      check_eq(tag, 73'(b_pc), 73'(0));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int nv;
      int n0;

      // Reset state
      tick(2);
      check_eq("rst_tvalid", 73'(a_mv), 73'(0));
      check_eq("rst_tready", 73'(a_sr), 73'(0));
      check_eq("rst_pkt_count", 73'(a_pc), 73'(0));
      check_eq("rst_drop_count", 73'(a_dc), 73'(0));
      check_eq("rst_tdata", 73'({a_ml, a_mk, a_md}), 73'(0));
      aresetn = 1'b1;
      tick(1);
      check_eq("tready_after_rst", 73'(a_sr), 73'(1));

      // 3-beat packet, latency and back-to-back output
      do_reset();
      a_mr = 1'b1;
      a_beat(64'd1, 8'hFF, 1'b0);
      a_beat(64'd2, 8'hFF, 1'b0);
      a_beat(64'd3, 8'h0F, 1'b1);
      a_idle();
      check_eq("t1_pkt_count_1", 73'(a_pc), 73'(1));
      lat = 0;
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         if (a_mv) begin
            lat = k;
            break;
         end
      end
      check_eq("t1_latency_le2", 73'(lat >= 1 && lat <= 2), 73'(1));
      tick(6);
      check_eq("t1_nbeats", 73'(a_got.size()), 73'(3));
      a_expect("t1_beat0", 0, 64'd1, 8'hFF, 1'b0);
      a_expect("t1_beat1", 1, 64'd2, 8'hFF, 1'b0);
      a_expect("t1_beat2", 2, 64'd3, 8'h0F, 1'b1);
      if (a_got.size() >= 3) check_eq("t1_consecutive", 73'(a_got[2].cyc - a_got[0].cyc), 73'(2));
      check_eq("t1_pkt_count_0", 73'(a_pc), 73'(0));

      // Uncommitted beats stay invisible
      do_reset();
      a_mr = 1'b1;
      a_beat(64'h10, 8'hFF, 1'b0);
      a_beat(64'h11, 8'hFF, 1'b0);
      a_idle();
      nv = 0;
      for (int k = 0; k < 100; k++) begin
         tick(1);
         if (a_mv) nv++;
      end
      check_eq("t2_no_tvalid", 73'(nv), 73'(0));
      a_beat(64'h12, 8'h03, 1'b1);
      a_idle();
      tick(8);
      check_eq("t2_nbeats", 73'(a_got.size()), 73'(3));
      a_expect("t2_beat0", 0, 64'h10, 8'hFF, 1'b0);
      a_expect("t2_beat1", 1, 64'h11, 8'hFF, 1'b0);
      a_expect("t2_beat2", 2, 64'h12, 8'h03, 1'b1);

      // Exactly full, then a packet that must be dropped
      do_reset();
      a_mr = 1'b0;
      for (int i = 0; i < 16; i++) a_beat(64'h100 + 64'(i), 8'hFF, i == 15);
      for (int i = 0; i < 4; i++) a_beat(64'h200 + 64'(i), 8'hFF, i == 3);
      a_idle();
      tick(3);
      check_eq("t3_drop_count", 73'(a_dc), 73'(1));
      check_eq("t3_pkt_count", 73'(a_pc), 73'(1));
      a_mr = 1'b1;
      tick(30);
      check_eq("t3_nbeats", 73'(a_got.size()), 73'(16));
      for (int i = 0; i < 16; i++) a_expect("t3_beat", i, 64'h100 + 64'(i), 8'hFF, i == 15);
      check_eq("t3_wr_ptr", 73'(u_a.r_wr_ptr), 73'(16));
      check_eq("t3_wr_commit", 73'(u_a.r_wr_commit), 73'(16));
      check_eq("t3_pkt_count_0", 73'(a_pc), 73'(0));

      // Packet of DEPTH+1 beats into an empty FIFO
      do_reset();
      a_mr = 1'b1;
      for (int i = 0; i < 17; i++) a_beat(64'h600 + 64'(i), 8'hFF, i == 16);
      a_idle();
      tick(10);
      check_eq("t4_drop_count", 73'(a_dc), 73'(1));
      check_eq("t4_no_output", 73'(a_got.size()), 73'(0));
      check_eq("t4_pkt_count", 73'(a_pc), 73'(0));
      a_beat(64'hABCD, 8'h3C, 1'b1);
      a_idle();
      tick(8);
      check_eq("t4_nbeats", 73'(a_got.size()), 73'(1));
      a_expect("t4_beat", 0, 64'hABCD, 8'h3C, 1'b1);

      // Reset mid-packet with a committed packet stored
      do_reset();
      a_mr = 1'b0;
      for (int i = 0; i < 17; i++) a_beat(64'h700 + 64'(i), 8'hFF, i == 16);
      a_beat(64'h300, 8'hFF, 1'b0);
      a_beat(64'h301, 8'hFF, 1'b1);
      a_beat(64'h400, 8'hFF, 1'b0);
      a_beat(64'h401, 8'hFF, 1'b0);
      tick(1);
      check_eq("t6_pre_drop", 73'(a_dc), 73'(1));
      check_eq("t6_pre_pkt", 73'(a_pc), 73'(1));
      aresetn = 1'b0;
      a_sv = 1'b0; a_sl = 1'b0;
      tick(1);
      check_eq("t6_tvalid", 73'(a_mv), 73'(0));
      check_eq("t6_tready", 73'(a_sr), 73'(0));
      check_eq("t6_drop_count", 73'(a_dc), 73'(0));
      check_eq("t6_pkt_count", 73'(a_pc), 73'(0));
      aresetn = 1'b1;
      tick(1);
      a_got.delete();
      a_mr = 1'b1;
      a_beat(64'h500, 8'hFF, 1'b0);
      a_beat(64'h501, 8'hFF, 1'b0);
      a_beat(64'h502, 8'h0F, 1'b1);
      a_idle();
      tick(8);
      check_eq("t6_nbeats", 73'(a_got.size()), 73'(3));
      a_expect("t6_beat0", 0, 64'h500, 8'hFF, 1'b0);
      a_expect("t6_beat1", 1, 64'h501, 8'hFF, 1'b0);
      a_expect("t6_beat2", 2, 64'h502, 8'h0F, 1'b1);

      // 64-beat packets, random ready, several pointer wraps of the DEPTH=128 instance
      do_reset();
      b_exp.delete();
      b_rand = 1'b1;
      for (int g = 0; g < 4; g++) begin
         b_pkt(2 * g);
         b_pkt(2 * g + 1);
         tick(1);
         b_sv = 1'b0; b_sl = 1'b0;
         b_wait_drain("t5_drain");
      end
      b_rand = 1'b0;
      tick(2);
      n0 = b_got.size();
      b_pkt(8);
      tick(1);
      b_sv = 1'b0; b_sl = 1'b0;
      b_wait_drain("t5_drain_full_rate");
      if (b_got.size() >= n0 + 64)
         check_eq("t5_throughput", 73'(b_got[n0 + 63].cyc - b_got[n0].cyc), 73'(63));
      check_eq("t5_nbeats", 73'(b_got.size()), 73'(b_exp.size()));
      check_eq("t5_drop_count", 73'(b_dc), 73'(0));
      for (int i = 0; i < b_exp.size(); i++) begin
         if (i < b_got.size()) check_eq("t5_beat", b_got[i].v, b_exp[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
